// File: rtl/div.sv
// rtl/div.sv - multi-cycle restoring divider for HI/LO results
//
// Purpose: 32-step restoring shift-subtract divider (signed DIV / unsigned
// DIVU). The request is held by the producer until the result is consumed.
//
// Ports:
//   clk          - sole clock, rising edge
//   rst          - synchronous active-high reset
//   signed_div_i - 1 = signed divide, 0 = unsigned
//   opdata1_i    - dividend
//   opdata2_i    - divisor
//   start_i      - request, held high until the result is consumed
//   annul_i      - cancel an in-flight division (pipeline flush)
//   result_o     - {remainder, quotient}
//   ready_o      - result_o valid

module div #(
  parameter int DIV_W = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 signed_div_i,
  input  logic [DIV_W-1:0]     opdata1_i,
  input  logic [DIV_W-1:0]     opdata2_i,
  input  logic                 start_i,
  input  logic                 annul_i,
  output logic [2*DIV_W-1:0]   result_o,
  output logic                 ready_o
);

  localparam int CW = $clog2(DIV_W + 1);

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BYZERO = 2'd1,
    ON     = 2'd2,
    END    = 2'd3
  } state_e;

  state_e               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  // {partial remainder (DIV_W+1 bits), dividend/quotient (DIV_W bits)}
  logic [2*DIV_W:0]     work_q, work_d;
  logic [DIV_W-1:0]     divisor_q, divisor_d;
  logic                 quo_neg_q, quo_neg_d;
  logic                 rem_neg_q, rem_neg_d;
  logic [2*DIV_W-1:0]   result_q, result_d;
  logic                 ready_q, ready_d;

  logic                 op1_neg, op2_neg;
  logic [DIV_W-1:0]     op1_mag, op2_mag;
  logic [DIV_W+1:0]     diff;
  logic [DIV_W-1:0]     quo_mag, rem_mag, quo_fix, rem_fix;

  always_comb begin
    op1_neg = signed_div_i & opdata1_i[DIV_W-1];
    op2_neg = signed_div_i & opdata2_i[DIV_W-1];
    // Magnitude of the most negative value wraps to itself, which is the
    // correct unsigned magnitude, so no overflow trap is needed.
    op1_mag = op1_neg ? -opdata1_i : opdata1_i;
    op2_mag = op2_neg ? -opdata2_i : opdata2_i;

    // Trial subtract on the remainder shifted left by one with the next
    // dividend bit brought in. The top work bit is always zero but keeps
    // the subtraction one bit wider so its sign is unambiguous.
    diff = work_q[2*DIV_W:DIV_W-1] - {2'b00, divisor_q};

    quo_mag = work_q[DIV_W-1:0];
    rem_mag = work_q[2*DIV_W-1:DIV_W];
    quo_fix = quo_neg_q ? -quo_mag : quo_mag;
    rem_fix = rem_neg_q ? -rem_mag : rem_mag;
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    work_d    = work_q;
    divisor_d = divisor_q;
    quo_neg_d = quo_neg_q;
    rem_neg_d = rem_neg_q;
    result_d  = result_q;
    ready_d   = ready_q;

    unique case (state_q)
      FREE: begin
        if (start_i && !annul_i) begin
          divisor_d = op2_mag;
          work_d    = {{(DIV_W+1){1'b0}}, op1_mag};
          cnt_d     = '0;
          quo_neg_d = op1_neg ^ op2_neg;
          rem_neg_d = op1_neg;
          state_d   = (opdata2_i == '0) ? BYZERO : ON;
        end
      end

      BYZERO: begin
        if (annul_i) begin
          state_d = FREE;
        end else begin
          result_d = '0;
          ready_d  = 1'b1;
          state_d  = END;
        end
      end

      ON: begin
        if (annul_i) begin
          cnt_d   = '0;
          state_d = FREE;
        end else if (cnt_q == CW'(DIV_W)) begin
          result_d = {rem_fix, quo_fix};
          ready_d  = 1'b1;
          state_d  = END;
        end else begin
          if (diff[DIV_W+1]) begin
            work_d = {work_q[2*DIV_W-1:0], 1'b0};
          end else begin
            work_d = {diff[DIV_W:0], work_q[DIV_W-2:0], 1'b1};
          end
          cnt_d = cnt_q + CW'(1);
        end
      end

      END: begin
        if (!start_i) begin
          result_d = '0;
          ready_d  = 1'b0;
          state_d  = FREE;
        end
      end

      default: state_d = FREE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= FREE;
      cnt_q     <= '0;
      work_q    <= '0;
      divisor_q <= '0;
      quo_neg_q <= 1'b0;
      rem_neg_q <= 1'b0;
      result_q  <= '0;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      work_q    <= work_d;
      divisor_q <= divisor_d;
      quo_neg_q <= quo_neg_d;
      rem_neg_q <= rem_neg_d;
      result_q  <= result_d;
      ready_q   <= ready_d;
    end
  end

  assign result_o = result_q;
  assign ready_o  = ready_q;

endmodule

// File: tb/tb_div.sv
// tb/tb_div.sv - directed self-checking bench for div

module tb_div;

  logic        clk = 1'b0;
  logic        rst;
  logic        signed_div;
  logic [31:0] op1, op2;
  logic        start, annul;
  logic [63:0] result;
  logic        ready;

  int n_checks = 0;
  int n_fail   = 0;

  div #(.DIV_W(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div),
    .opdata1_i    (op1),
    .opdata2_i    (op2),
    .start_i      (start),
    .annul_i      (annul),
    .result_o     (result),
    .ready_o      (ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%016h expected 0x%016h", tag, got, exp);
    end
  endtask

  task automatic start_div(input logic s, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    signed_div = s;
    op1        = a;
    op2        = b;
    start      = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Counts edges after acceptance until ready_o, bounded to 100 edges.
  task automatic wait_ready(input string tag, input int exp_lat, input logic [63:0] exp_res,
                            input bit wiggle);
    int n = 0;
    while (!ready && n < 100) begin
      if (wiggle) begin
        op1        = $urandom;
        op2        = $urandom;
        signed_div = 1'($urandom);
      end
      @(posedge clk);
      #1;
      n++;
    end
    check({tag, "_lat"}, 64'(n), 64'(exp_lat));
    check({tag, "_res"}, result, exp_res);
  endtask

  // Holds start for one edge (with annul pulsed, which must be ignored in END),
  // then drops start and expects a return to idle outputs.
  task automatic finish_div(input string tag, input logic [63:0] exp_res);
    @(negedge clk);
    annul = 1'b1;
    @(posedge clk);
    #1;
    check({tag, "_hold_rdy"}, 64'(ready), 64'd1);
    check({tag, "_hold_res"}, result, exp_res);
    @(negedge clk);
    annul = 1'b0;
    start = 1'b0;
    @(posedge clk);
    #1;
    check({tag, "_drop_rdy"}, 64'(ready), 64'd0);
    check({tag, "_drop_res"}, result, 64'd0);
  endtask

  task automatic run_div(input string tag, input logic s, input logic [31:0] a,
                         input logic [31:0] b, input int lat, input logic [63:0] res);
    start_div(s, a, b);
    wait_ready(tag, lat, res, 1'b0);
    finish_div(tag, res);
  endtask

  initial begin
    rst        = 1'b1;
    signed_div = 1'b0;
    op1        = '0;
    op2        = '0;
    start      = 1'b0;
    annul      = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_rdy", 64'(ready), 64'd0);
    check("rst_res", result, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("idle_rdy", 64'(ready), 64'd0);

    run_div("u100_7",   1'b0, 32'd100,        32'd7,        33, 64'h00000002_0000000E);
    run_div("s_m7_2",   1'b1, 32'hFFFFFFF9,   32'd2,        33, 64'hFFFFFFFF_FFFFFFFD);
    run_div("u_m7_2",   1'b0, 32'hFFFFFFF9,   32'd2,        33, 64'h00000001_7FFFFFFC);
    run_div("s_7_m2",   1'b1, 32'd7,          32'hFFFFFFFE, 33, 64'h00000001_FFFFFFFD);
    run_div("s_m7_m2",  1'b1, 32'hFFFFFFF9,   32'hFFFFFFFE, 33, 64'hFFFFFFFF_00000003);
    run_div("u_max_1",  1'b0, 32'hFFFFFFFF,   32'd1,        33, 64'h00000000_FFFFFFFF);
    run_div("u_5_max",  1'b0, 32'd5,          32'hFFFFFFFF, 33, 64'h00000005_00000000);
    run_div("zero_5",   1'b1, 32'd0,          32'd5,        33, 64'h0);
    run_div("u_byzero", 1'b0, 32'd123,        32'd0,         1, 64'h0);
    run_div("s_byzero", 1'b1, 32'hFFFFFFF9,   32'd0,         1, 64'h0);
    run_div("s_ovf",    1'b1, 32'h80000000,   32'hFFFFFFFF, 33, 64'h00000000_80000000);

    // Operand wiggle after acceptance must not disturb the result.
    start_div(1'b1, 32'h80000000, 32'hFFFFFFFF);
    wait_ready("ovf_wiggle", 33, 64'h00000000_80000000, 1'b1);
    finish_div("ovf_wiggle", 64'h00000000_80000000);

    // Annul at iteration 10, then restart on the following edge.
    start_div(1'b0, 32'd100, 32'd7);
    repeat (10) begin
      @(posedge clk);
      #1;
    end
    check("annul_pre_rdy", 64'(ready), 64'd0);
    @(negedge clk);
    annul = 1'b1;
    op1   = 32'd1000;
    op2   = 32'd10;
    @(posedge clk);
    #1;
    check("annul_rdy", 64'(ready), 64'd0);
    check("annul_res", result, 64'd0);
    @(negedge clk);
    annul = 1'b0;
    @(posedge clk);
    #1;
    wait_ready("annul_restart", 33, 64'h00000000_00000064, 1'b0);
    finish_div("annul_restart", 64'h00000000_00000064);

    // Annul in BYZERO returns to FREE without a result.
    start_div(1'b0, 32'd5, 32'd0);
    @(negedge clk);
    annul = 1'b1;
    @(posedge clk);
    #1;
    check("annul_bz_rdy", 64'(ready), 64'd0);
    @(negedge clk);
    annul = 1'b0;
    start = 1'b0;
    @(posedge clk);
    #1;

    // Annul held in FREE blocks acceptance; acceptance follows its release.
    @(negedge clk);
    signed_div = 1'b0;
    op1        = 32'd77;
    op2        = 32'd10;
    start      = 1'b1;
    annul      = 1'b1;
    @(posedge clk);
    @(negedge clk);
    annul = 1'b0;
    @(posedge clk);
    #1;
    wait_ready("annul_free", 33, 64'h00000007_00000007, 1'b0);
    finish_div("annul_free", 64'h00000007_00000007);

    // Reset mid-ON.
    start_div(1'b0, 32'd100, 32'd7);
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("rst_on_rdy", 64'(ready), 64'd0);
    check("rst_on_res", result, 64'd0);
    @(negedge clk);
    rst   = 1'b0;
    start = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    check("rst_on_idle", 64'(ready), 64'd0);

    // Reset in END.
    start_div(1'b0, 32'd100, 32'd7);
    wait_ready("pre_rst_end", 33, 64'h00000002_0000000E, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("rst_end_rdy", 64'(ready), 64'd0);
    check("rst_end_res", result, 64'd0);
    @(negedge clk);
    rst   = 1'b0;
    start = 1'b0;
    @(posedge clk);
    #1;
    run_div("post_rst", 1'b0, 32'd100, 32'd7, 33, 64'h00000002_0000000E);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
